updown_mod_counter: RTL and testbench

- Parametrised synchronous up/down counter: programmable modulus, parallel load, count enable, free-run or one-shot mode.
- Terminal-count output lets instances cascade into wider counters.
- Successor to the 4-bit ripple counter built from toggle flip-flops: all state changes on one clock edge, so there is no ripple skew.
- General-purpose timing and event-counting primitive for the datapath and control blocks.

---
 rtl/counter_pkg.sv | 30 +++
 rtl/count_next.sv | 47 ++++
 rtl/updown_mod_counter.sv | 101 ++++++++++
 tb/tb_updown_mod_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants, state encoding and helpers for the up/down modulus counter.
package counter_pkg;

    // Direction encoding for the 'up' input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Mode encoding for the 'one_shot' input.
    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Counter control state: COUNTING while done=0, DONE once a one-shot has finished.
    typedef enum logic {
        ST_COUNTING = 1'b0,
        ST_DONE     = 1'b1
    } cnt_state_t;

    // Ceiling log2, used to check that the modulus fits in the counter width.
    function automatic int clog2(input longint unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 64; i++) begin
            if ((64'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/count_next.sv
// Next-value and terminal detection for a modulus counter.
// Purely combinational; the caller owns the state registers.
module count_next
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] next_q,
    output logic             at_terminal
);

    // MODULUS itself needs WIDTH+1 bits when it equals 2**WIDTH.
    localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_V = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] TOP_Q = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;
    logic           w_up_term;
    logic           w_down_term;

    assign w_q_ext = {1'b0, q};
    assign w_inc   = w_q_ext + ONE_V;
    assign w_dec   = w_q_ext - ONE_V;

    // Up-terminal is q+1 reaching the modulus; down-terminal is the borrow out of q-1.
    assign w_up_term   = (w_inc == MOD_V);
    assign w_down_term = w_dec[WIDTH];

    // Select terminal flag and next value for the current direction; wrap at the ends.
    always_comb begin
        at_terminal = 1'b0;
        next_q      = q;
        if (up == DIR_UP) begin
            at_terminal = w_up_term;
            next_q      = w_up_term ? '0 : w_inc[WIDTH-1:0];
        end else begin
            at_terminal = w_down_term;
            next_q      = w_down_term ? TOP_Q : w_dec[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulus counter with parallel load, count enable and
// one-shot mode. tc is combinational so it can drive the enable of a
// following stage and cascade into wider counters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_COUNTING | done=0; counts when en=1, wraps at terminal if free-running
// ST_DONE     | done=1; one-shot reached terminal, q frozen until load/reset
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("updown_mod_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH) || clog2(MODULUS) > int'(WIDTH)) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP_Q = WIDTH'(MODULUS - 64'd1);

    cnt_state_t       r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_done;

    logic [WIDTH-1:0] w_next_q;
    logic             w_at_term;
    logic             w_din_ok;
    logic [WIDTH-1:0] w_load_q;

    count_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_count_next (
        .q           (r_q),
        .up          (up),
        .next_q      (w_next_q),
        .at_terminal (w_at_term)
    );

    // Out-of-range load values saturate to the top state so q never leaves 0..MODULUS-1.
    assign w_din_ok = ({1'b0, din} < MOD_V);
    assign w_load_q = w_din_ok ? din : TOP_Q;

    // Priority: reset > load > count (only while COUNTING) > hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_COUNTING;
            r_q     <= '0;
            r_done  <= 1'b0;
        end else if (load) begin
            r_state <= ST_COUNTING;
            r_q     <= w_load_q;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_COUNTING: begin
                    if (en) begin
                        if (w_at_term && (one_shot == MODE_ONESHOT)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_q <= w_next_q;
                        end
                    end
                end
                ST_DONE: begin
                    // Only load or reset leave DONE; one_shot going low does not.
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_COUNTING;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign done = r_done;

    // Carry out: high for the enabled cycle whose edge would wrap (or finish a one-shot).
    assign tc = reset & en & ~r_done & w_at_term;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: WIDTH=4, MODULUS=10 single stage,
// plus a two-stage decade cascade.
module tb_updown_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic       one_shot;
    logic [3:0] q;
    logic       tc;
    logic       done;

    logic       c_reset;
    logic       c_en;
    logic       c_load;
    logic [3:0] c_din;
    logic       c_one_shot;
    logic       c_up;
    logic [3:0] lo_q;
    logic       lo_tc;
    logic       lo_done;
    logic [3:0] hi_q;
    logic       hi_tc;
    logic       hi_done;

    int n_checks;
    int n_pass;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
        .one_shot(one_shot), .q(q), .tc(tc), .done(done)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .reset(c_reset), .en(c_en), .up(c_up), .load(c_load), .din(c_din),
        .one_shot(c_one_shot), .q(lo_q), .tc(lo_tc), .done(lo_done)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .reset(c_reset), .en(lo_tc), .up(c_up), .load(c_load), .din(c_din),
        .one_shot(c_one_shot), .q(hi_q), .tc(hi_tc), .done(hi_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b0;
        en         = 1'b1;
        up         = 1'b0;
        load       = 1'b0;
        din        = 4'd0;
        one_shot   = 1'b0;
        c_reset    = 1'b0;
        c_en       = 1'b0;
        c_load     = 1'b0;
        c_din      = 4'd0;
        c_one_shot = 1'b0;
        c_up       = 1'b1;

        // Reset for 2 cycles; q=0 with up=0 is terminal, so tc must be gated by reset.
        tick();
        tick();
        check("reset_q", 32'(q), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_tc", 32'(tc), 32'd0);

        // Free-run up: 0..9,0,1 with tc only at 9.
        reset = 1'b1;
        up    = 1'b1;
        settle();
        for (int i = 0; i < 12; i++) begin
            check("up_q", 32'(q), 32'(i % 10));
            check("up_tc", 32'(tc), (i % 10 == 9) ? 32'd1 : 32'd0);
            tick();
        end

        // Load 3 then count down: 3,2,1,0,9,8 with tc only at 0.
        en   = 1'b0;
        load = 1'b1;
        din  = 4'd3;
        tick();
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b0;
        settle();
        for (int i = 0; i < 6; i++) begin
            check("down_q", 32'(q), 32'((13 - i) % 10));
            check("down_tc", 32'(tc), (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check("down_after_q", 32'(q), 32'd7);

        // Load clipping and load-over-count priority.
        load = 1'b1;
        en   = 1'b1;
        up   = 1'b1;
        din  = 4'd13;
        tick();
        check("clip13_q", 32'(q), 32'd9);
        din = 4'd10;
        tick();
        check("clip10_q", 32'(q), 32'd9);
        din = 4'd9;
        tick();
        check("load9_q", 32'(q), 32'd9);
        din = 4'd4;
        tick();
        check("load_wins_q", 32'(q), 32'd4);

        // One-shot: 7,8,9 then hold at 9 with done set.
        en       = 1'b0;
        one_shot = 1'b1;
        din      = 4'd7;
        tick();
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        settle();
        check("os_q7", 32'(q), 32'd7);
        check("os_done7", 32'(done), 32'd0);
        check("os_tc7", 32'(tc), 32'd0);
        tick();
        check("os_q8", 32'(q), 32'd8);
        tick();
        check("os_q9", 32'(q), 32'd9);
        check("os_tc9", 32'(tc), 32'd1);
        check("os_done9", 32'(done), 32'd0);
        tick();
        check("os_hold_q", 32'(q), 32'd9);
        check("os_done", 32'(done), 32'd1);
        check("os_tc_after", 32'(tc), 32'd0);
        tick();
        check("os_hold2_q", 32'(q), 32'd9);
        one_shot = 1'b0;
        tick();
        check("os_sticky_done", 32'(done), 32'd1);
        check("os_sticky_q", 32'(q), 32'd9);
        check("os_sticky_tc", 32'(tc), 32'd0);
        load = 1'b1;
        din  = 4'd0;
        tick();
        check("os_clear_done", 32'(done), 32'd0);
        check("os_clear_q", 32'(q), 32'd0);

        // Count to 5, then synchronous reset mid-count.
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("pre_reset_q", 32'(q), 32'd5);
        reset = 1'b0;
        up    = 1'b0;
        tick();
        check("mid_reset_q", 32'(q), 32'd0);
        check("mid_reset_done", 32'(done), 32'd0);
        check("mid_reset_tc", 32'(tc), 32'd0);
        reset = 1'b1;
        settle();
        check("release_tc", 32'(tc), 32'd1);

        // Two-stage decade cascade: after k enabled clocks hi:lo reads k.
        c_reset = 1'b1;
        c_en    = 1'b1;
        settle();
        check("casc_start", 32'({hi_q, lo_q}), 32'h00);
        for (int i = 0; i < 99; i++) tick();
        check("casc_99", 32'({hi_q, lo_q}), 32'h99);
        check("casc_lo_tc", 32'(lo_tc), 32'd1);
        check("casc_hi_tc", 32'(hi_tc), 32'd1);
        tick();
        check("casc_100", 32'({hi_q, lo_q}), 32'h00);
        check("casc_done", 32'({hi_done, lo_done}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
